coherence_bus_arbiter: RTL and testbench



---
 rtl/coherence_bus_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_coherence_bus_arbiter.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/coherence_bus_arbiter.sv
// N-way snoop-bus arbiter: writebacks beat reads up to a streak limit, round-robin within a class.
// Optional watchdog release is compiled in with `define BUS_ARB_TIMEOUT_EN.
module coherence_bus_arbiter #(
    parameter int CPUS           = 4,
    parameter int MAX_WB_STREAK  = 3,
    parameter int TIMEOUT_CYCLES = 255,
    localparam int CPU_ID_W      = $clog2(CPUS)
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [CPUS-1:0]     req,
    input  logic [CPUS-1:0]     req_wb,
    input  logic                txn_done,
    output logic [CPUS-1:0]     gnt,
    output logic                gnt_valid,
    output logic [CPU_ID_W-1:0] gnt_id,
    output logic                gnt_wb,
    output logic                timeout_err
);

    localparam int SW = $clog2(MAX_WB_STREAK + 1);
    localparam logic [CPUS-1:0] ONE_HOT0 = {{(CPUS-1){1'b0}}, 1'b1};

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [CPUS-1:0]     gnt_q, gnt_d;
    logic                gnt_valid_q, gnt_valid_d;
    logic [CPU_ID_W-1:0] gnt_id_q, gnt_id_d;
    logic                gnt_wb_q, gnt_wb_d;
    logic [CPU_ID_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [SW-1:0]       wb_streak_q, wb_streak_d;

    logic [CPUS-1:0]     wb_set, rd_set, cand;
    logic                use_wb;
    logic [CPU_ID_W-1:0] win_id;

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int WD = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD-1:0]       wdog_q, wdog_d;
    logic                timeout_err_q, timeout_err_d;
`endif

    // First set bit of cand scanning upward from ptr, wrapping explicitly at CPUS.
    function automatic logic [CPU_ID_W-1:0] pick_winner(input logic [CPUS-1:0] c,
                                                        input logic [CPU_ID_W-1:0] ptr);
        logic [CPU_ID_W-1:0] win;
        logic                found;
        int                  idx;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < CPUS; i++) begin
            idx = int'(ptr) + i;
            if (idx >= CPUS) begin
                idx = idx - CPUS;
            end else begin
                idx = idx;
            end
            if (!found && c[idx]) begin
                found = 1'b1;
                win   = CPU_ID_W'(idx);
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

    // Class selection and winner choice for the current request set.
    always_comb begin
        wb_set = req & req_wb;
        rd_set = req & ~req_wb;
        use_wb = (wb_set != '0) && ((rd_set == '0) || (wb_streak_q < SW'(MAX_WB_STREAK)));
        cand   = use_wb ? wb_set : rd_set;
        win_id = pick_winner(cand, rr_ptr_q);
    end

    // Next-state logic for the grant FSM.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gnt_valid_d = gnt_valid_q;
        gnt_id_d    = gnt_id_q;
        gnt_wb_d    = gnt_wb_q;
        rr_ptr_d    = rr_ptr_q;
        wb_streak_d = wb_streak_q;
`ifdef BUS_ARB_TIMEOUT_EN
        wdog_d        = wdog_q;
        timeout_err_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d     = BUSY;
                    gnt_d       = ONE_HOT0 << win_id;
                    gnt_valid_d = 1'b1;
                    gnt_id_d    = win_id;
                    gnt_wb_d    = use_wb;
                    rr_ptr_d    = (win_id == CPU_ID_W'(CPUS - 1)) ? '0 : win_id + CPU_ID_W'(1);
                    if (use_wb && (rd_set != '0)) begin
                        wb_streak_d = (wb_streak_q == SW'(MAX_WB_STREAK)) ? wb_streak_q
                                                                         : wb_streak_q + SW'(1);
                    end else begin
                        wb_streak_d = '0;
                    end
`ifdef BUS_ARB_TIMEOUT_EN
                    wdog_d = '0;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                if (txn_done) begin
                    state_d     = IDLE;
                    gnt_d       = '0;
                    gnt_valid_d = 1'b0;
                    gnt_id_d    = '0;
                    gnt_wb_d    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
                end else if (wdog_q == WD'(TIMEOUT_CYCLES)) begin
                    state_d       = IDLE;
                    gnt_d         = '0;
                    gnt_valid_d   = 1'b0;
                    gnt_id_d      = '0;
                    gnt_wb_d      = 1'b0;
                    timeout_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + WD'(1);
`else
                end else begin
                    state_d = BUSY;
`endif
                end
            end
            default: begin
                state_d     = IDLE;
                gnt_d       = '0;
                gnt_valid_d = 1'b0;
                gnt_id_d    = '0;
                gnt_wb_d    = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_valid_q <= 1'b0;
            gnt_id_q    <= '0;
            gnt_wb_q    <= 1'b0;
            rr_ptr_q    <= '0;
            wb_streak_q <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_valid_q <= gnt_valid_d;
            gnt_id_q    <= gnt_id_d;
            gnt_wb_q    <= gnt_wb_d;
            rr_ptr_q    <= rr_ptr_d;
            wb_streak_q <= wb_streak_d;
`ifdef BUS_ARB_TIMEOUT_EN
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign gnt_valid = gnt_valid_q;
    assign gnt_id    = gnt_id_q;
    assign gnt_wb    = gnt_wb_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed bench for coherence_bus_arbiter: cycle-by-cycle vector table plus watchdog sequences.
module tb_coherence_bus_arbiter;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [3:0] req = 4'b0000;
    logic [3:0] req_wb = 4'b0000;
    logic       txn_done = 1'b0;
    logic [3:0] gnt;
    logic       gnt_valid;
    logic [1:0] gnt_id;
    logic       gnt_wb;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] wb;
        logic       done;
        logic [3:0] egnt;
        logic [1:0] eid;
        logic       ewb;
    } vec_t;

    vec_t vecs[$];

    coherence_bus_arbiter #(
        .CPUS(4), .MAX_WB_STREAK(3), .TIMEOUT_CYCLES(8)
    ) dut (
        .CLK(CLK), .RST(RST), .req(req), .req_wb(req_wb), .txn_done(txn_done),
        .gnt(gnt), .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_wb(gnt_wb),
        .timeout_err(timeout_err)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic step(input logic r, input logic [3:0] q, input logic [3:0] w, input logic d);
        RST = r; req = q; req_wb = w; txn_done = d;
        @(posedge CLK);
        #1;
    endtask

    task automatic add(input logic r, input logic [3:0] q, input logic [3:0] w, input logic d,
                       input logic [3:0] eg, input logic [1:0] ei, input logic ew);
        vecs.push_back('{r, q, w, d, eg, ei, ew});
    endtask

    int hits;
    int drops;
    int rel_at;
    logic err_at_rel;

    initial begin
        // single request, grant held, release on txn_done, stray done in IDLE
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
        add(0, 4'b0100, 4'b0000, 0, 4'b0100, 2'd2, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0100, 4'b0000, 0, 4'b0100, 2'd2, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0);
        // round robin 0,1,2,3,0 with one idle cycle after each done
        add(1, 4'b0000, 4'b0000, 0, 4'b0000, 2'd0, 0);
        for (int k = 0; k < 4; k++) begin
            add(0, 4'b1111, 4'b0000, 0, 4'b0001 << k, 2'(k), 0);
            add(0, 4'b1111, 4'b0000, 0, 4'b0001 << k, 2'(k), 0);
            add(0, 4'b1111, 4'b0000, 0, 4'b0001 << k, 2'(k), 0);
            add(0, 4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0);
        end
        add(0, 4'b1111, 4'b0000, 0, 4'b0001, 2'd0, 0);
        add(0, 4'b1111, 4'b0000, 1, 4'b0000, 2'd0, 0);
        // writeback priority with streak limit: 1,2,3 wb, then read 0, then wb 1
        add(0, 4'b1111, 4'b1110, 0, 4'b0010, 2'd1, 1);
        add(0, 4'b1111, 4'b1110, 1, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b1110, 0, 4'b0100, 2'd2, 1);
        add(0, 4'b1111, 4'b1110, 1, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b1110, 0, 4'b1000, 2'd3, 1);
        add(0, 4'b1111, 4'b1110, 1, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b1110, 0, 4'b0001, 2'd0, 0);
        add(0, 4'b1111, 4'b1110, 1, 4'b0000, 2'd0, 0);
        add(0, 4'b1111, 4'b1110, 0, 4'b0010, 2'd1, 1);
        add(0, 4'b1111, 4'b1110, 1, 4'b0000, 2'd0, 0);
        // grant held while requester drops, then stray done while idle
        add(0, 4'b1000, 4'b0000, 0, 4'b1000, 2'd3, 0);
        for (int i = 0; i < 4; i++) add(0, 4'b0000, 4'b0000, 0, 4'b1000, 2'd3, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0);
        // reset mid-transaction returns rr_ptr to 0
        add(0, 4'b0010, 4'b0000, 0, 4'b0010, 2'd1, 0);
        add(1, 4'b0011, 4'b0000, 0, 4'b0000, 2'd0, 0);
        add(0, 4'b0011, 4'b0000, 0, 4'b0001, 2'd0, 0);
        add(0, 4'b0000, 4'b0000, 1, 4'b0000, 2'd0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].req, vecs[i].wb, vecs[i].done);
            check($sformatf("v%0d.gnt", i), 32'(gnt), 32'(vecs[i].egnt));
            check($sformatf("v%0d.valid", i), 32'(gnt_valid), 32'(vecs[i].egnt != 4'b0000));
            check($sformatf("v%0d.id", i), 32'(gnt_id), 32'(vecs[i].eid));
            check($sformatf("v%0d.wb", i), 32'(gnt_wb), 32'(vecs[i].ewb));
            check($sformatf("v%0d.terr", i), 32'(timeout_err), 32'd0);
        end

`ifdef BUS_ARB_TIMEOUT_EN
        // watchdog release nine cycles after the grant
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0000, 0);
        check("to.grant", 32'(gnt), 32'd1);
        rel_at = 0;
        err_at_rel = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            step(0, 4'b0000, 4'b0000, 0);
            if (!gnt_valid && rel_at == 0) begin
                rel_at = k;
                err_at_rel = timeout_err;
            end
        end
        check("to.release_cycle", 32'(rel_at), 32'd9);
        check("to.err_pulse", 32'(err_at_rel), 32'd1);
        check("to.err_after", 32'(timeout_err), 32'd0);
        // txn_done on the limit cycle wins over the watchdog
        step(0, 4'b0001, 4'b0000, 0);
        check("to2.grant", 32'(gnt), 32'd1);
        for (int k = 0; k < 8; k++) step(0, 4'b0000, 4'b0000, 0);
        check("to2.held", 32'(gnt), 32'd1);
        step(0, 4'b0000, 4'b0000, 1);
        check("to2.gnt", 32'(gnt), 32'd0);
        check("to2.err", 32'(timeout_err), 32'd0);
`else
        // without the watchdog a grant persists and timeout_err never fires
        step(1, 4'b0000, 4'b0000, 0);
        step(0, 4'b0001, 4'b0000, 0);
        check("noto.grant", 32'(gnt), 32'd1);
        hits = 0;
        drops = 0;
        for (int k = 0; k < 1000; k++) begin
            step(0, 4'b0000, 4'b0000, 0);
            if (timeout_err) hits++;
            if (gnt != 4'b0001) drops++;
        end
        check("noto.err_hits", 32'(hits), 32'd0);
        check("noto.gnt_drops", 32'(drops), 32'd0);
        step(0, 4'b0000, 4'b0000, 1);
        check("noto.release", 32'(gnt), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
